pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and redirect controller for the in-order MIPS pipeline. It sits beside decode and replaces the fixed two-stage RAW compare and the two-cycle jump/branch flush. It tracks pending register writes through NUM_STAGES post-decode stages in a destination scoreboard. From that it drives the decode stall, the decode bubble (flush), optional forwarding selects, and saturating stall and flush event counters.

Parameters:
REG_AW, 5, register-address width
NUM_STAGES, 3, tracked stages after decode (slot 0 = execute, slot NUM_STAGES-1 = writeback); minimum 2
FLUSH_DEPTH, 2, decode slots killed per redirect; minimum 1
CNT_W, 16, width of event counters

Ports:
clock  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
hold  in  1  global freeze (SREC load / memory hold): scoreboard, flush counter and event counters keep their values
dec_valid  in  1  decode holds a real instruction
dec_rs  in  REG_AW  decode source register A
dec_rt  in  REG_AW  decode source register B
dec_read_rs  in  1  decode reads rs
dec_read_rt  in  1  decode reads rt
dec_we  in  1  decode instruction writes a register
dec_rd  in  REG_AW  final destination (rd or rt already selected)
dec_is_load  in  1  decode instruction is a load
ex_redirect  in  1  execute slot resolves a jump or taken branch this cycle
raw_stall  out  1  hold fetch and decode; inject a NOP into execute
flush_dec  out  1  force the decode instruction to a NOP
fwd_rs_sel  out  FS_W  rs operand source (FS_W = clog2(NUM_STAGES))
fwd_rt_sel  out  FS_W  rt operand source
stall_cnt  out  CNT_W  cycles with raw_stall=1
flush_cnt  out  CNT_W  redirect events

Behaviour:
- Scoreboard: slot[i] = {v, rd, ld}, i = 0..NUM_STAGES-1.
- On each clock edge with hold=0: slot[i] <= slot[i-1] for i >= 1.
- slot[0] <= {dec_valid & dec_we & (dec_rd != 0) & ~raw_stall & ~flush_dec, dec_rd, dec_is_load}. A stalled or flushed instruction therefore enters as a bubble.
- The writeback slot (NUM_STAGES-1) writes the register file. The register file is write-before-read, so this slot never causes a stall or a forward.
- Match on slot i for source s: slot[i].v & (s == slot[i].rd) & read_s & dec_valid & (s != 0). Register 0 never matches.
- raw_stall (combinational), forwarding disabled: 1 if either source matches any slot 0..NUM_STAGES-2.
- flush_dec = ex_redirect | (fcnt != 0).
- When flush_dec = 1, raw_stall is forced to 0. The decode instruction is being killed, so redirect has priority over a RAW stall.
- Flush counter fcnt, width clog2(FLUSH_DEPTH+1):
  - ex_redirect & ~hold: fcnt <= FLUSH_DEPTH-1 (reload, even if fcnt is nonzero).
  - else if fcnt != 0 & ~hold: fcnt <= fcnt-1.
  - Total decode slots flushed = FLUSH_DEPTH.
- stall_cnt increments on edges with raw_stall & ~hold. flush_cnt increments on edges with ex_redirect & ~hold. Both saturate at all-ones and never wrap.
- hold = 1: all state is frozen. Combinational outputs still track their inputs.
- Reset (asynchronous, reset_n = 0): all slot v = 0, fcnt = 0, both counters = 0.
- Output values while in reset: raw_stall = 0, flush_dec = ex_redirect, fwd_*_sel = 0.
- Reset asserted mid-stall or mid-flush abandons the event immediately.
- Simultaneous ex_redirect and a RAW match: flush_dec = 1, raw_stall = 0, stall_cnt not incremented.

Optional Feature:
Macro PIPE_HAZARD_FWD_EN.
- Defined: fwd_s_sel = k+1 for the lowest-index slot k in 0..NUM_STAGES-2 that matches s; 0 means the register file.
- Defined: raw_stall = 1 only on load-use, i.e. slot[0] matches a source and slot[0].ld = 1; in that case both selects are 0.
- Undefined: fwd_*_sel is tied to 0 and the stall rule above applies.

Test Plan:
- reset_n low for 2 cycles mid-activity -> all outputs 0, counters 0, scoreboard empty on release.
- Issue addi r5 (we, rd=5), then add r6,r5,r5, no FWD -> raw_stall = 1 for exactly NUM_STAGES-1 = 2 cycles, then 0. stall_cnt = 2.
- Same sequence with PIPE_HAZARD_FWD_EN -> raw_stall never asserts; fwd_rs_sel = fwd_rt_sel = 1. Next instruction reading r5 sees sel = 2.
- lw r8 then sub r9,r8,r1 with FWD -> 1-cycle raw_stall, then fwd_rs_sel = 2. stall_cnt = 1.
- ex_redirect pulse, FLUSH_DEPTH = 2 -> flush_dec high 2 cycles; a second redirect in cycle 2 extends it to 3 total; flush_cnt = 2. A RAW match during the flush gives raw_stall = 0.
- hold = 1 for 4 cycles during a stall -> slots, fcnt and counters unchanged. Writes to r0 never stall. Set CNT_W = 2 and force 5 stall cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and redirect controller: destination scoreboard, decode stall/flush, event counters.
// Optional operand forwarding is enabled by defining PIPE_HAZARD_FWD_EN.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned FS_W       = $clog2(NUM_STAGES)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic              dec_read_rs,
    input  logic              dec_read_rt,
    input  logic              dec_we,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_is_load,
    input  logic              ex_redirect,
    output logic              raw_stall,
    output logic              flush_dec,
    output logic [FS_W-1:0]   fwd_rs_sel,
    output logic [FS_W-1:0]   fwd_rt_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned FC_W = $clog2(FLUSH_DEPTH + 1);

    logic [NUM_STAGES-1:0] slot_v;
    logic [NUM_STAGES-1:0] slot_ld;
    logic [REG_AW-1:0]     slot_rd [NUM_STAGES];
    logic [FC_W-1:0]       fcnt;
    logic [NUM_STAGES-2:0] match_rs;
    logic [NUM_STAGES-2:0] match_rt;
    logic                  stall_req;
    logic                  entry_v;

    // The writeback slot is excluded: the register file is write-before-read.
    always_comb begin
        match_rs = '0;
        match_rt = '0;
        for (int i = 0; i < NUM_STAGES - 1; i++) begin
            match_rs[i] = slot_v[i] && dec_valid && dec_read_rs && (dec_rs != '0)
                          && (dec_rs == slot_rd[i]);
            match_rt[i] = slot_v[i] && dec_valid && dec_read_rt && (dec_rt != '0)
                          && (dec_rt == slot_rd[i]);
        end
    end

`ifdef PIPE_HAZARD_FWD_EN
    logic load_use;

    assign load_use  = slot_ld[0] && (match_rs[0] || match_rt[0]);
    assign stall_req = load_use;

    // Walk from the oldest tracked slot down so the youngest producer wins.
    always_comb begin
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        for (int k = int'(NUM_STAGES) - 2; k >= 0; k--) begin
            if (match_rs[k]) fwd_rs_sel = FS_W'(k + 1);
            if (match_rt[k]) fwd_rt_sel = FS_W'(k + 1);
        end
        if (load_use) begin
            fwd_rs_sel = '0;
            fwd_rt_sel = '0;
        end
    end
`else
    assign stall_req  = |{match_rs, match_rt};
    assign fwd_rs_sel = '0;
    assign fwd_rt_sel = '0;
`endif

    assign flush_dec = ex_redirect || (fcnt != '0);
    assign raw_stall = stall_req && !flush_dec;
    assign entry_v   = dec_valid && dec_we && (dec_rd != '0) && !raw_stall && !flush_dec;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_v    <= '0;
            slot_ld   <= '0;
            for (int i = 0; i < NUM_STAGES; i++) slot_rd[i] <= '0;
            fcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!hold) begin
            slot_v     <= {slot_v[NUM_STAGES-2:0], entry_v};
            slot_ld    <= {slot_ld[NUM_STAGES-2:0], dec_is_load};
            slot_rd[0] <= dec_rd;
            for (int i = 1; i < NUM_STAGES; i++) slot_rd[i] <= slot_rd[i-1];

            if (ex_redirect) begin
                fcnt <= FC_W'(FLUSH_DEPTH - 1);
            end else if (fcnt != '0) begin
                fcnt <= fcnt - FC_W'(1);
            end

            if (raw_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ex_redirect && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    logic unused_wb;
    assign unused_wb = ^{slot_v[NUM_STAGES-1], slot_rd[NUM_STAGES-1], slot_ld};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: queue-based reference model plus directed literals.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int NS = 3;
    localparam int FD = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       hold = 1'b0;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_rs = '0, dec_rt = '0, dec_rd = '0;
    logic       dec_read_rs = 1'b0, dec_read_rt = 1'b0, dec_we = 1'b0, dec_is_load = 1'b0;
    logic       ex_redirect = 1'b0;

    logic        raw_stall, flush_dec;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_raw_stall, s_flush_dec;
    logic [1:0]  s_fwd_rs_sel, s_fwd_rt_sel;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.REG_AW(5), .NUM_STAGES(NS), .FLUSH_DEPTH(FD), .CNT_W(16)) u_dut (
        .clock(clock), .reset_n(reset_n), .hold(hold), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_read_rs(dec_read_rs), .dec_read_rt(dec_read_rt),
        .dec_we(dec_we), .dec_rd(dec_rd), .dec_is_load(dec_is_load), .ex_redirect(ex_redirect),
        .raw_stall(raw_stall), .flush_dec(flush_dec), .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .NUM_STAGES(NS), .FLUSH_DEPTH(FD), .CNT_W(2)) u_sat (
        .clock(clock), .reset_n(reset_n), .hold(hold), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_read_rs(dec_read_rs), .dec_read_rt(dec_read_rt),
        .dec_we(dec_we), .dec_rd(dec_rd), .dec_is_load(dec_is_load), .ex_redirect(ex_redirect),
        .raw_stall(s_raw_stall), .flush_dec(s_flush_dec), .fwd_rs_sel(s_fwd_rs_sel),
        .fwd_rt_sel(s_fwd_rt_sel), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } ent_t;

    ent_t hist[$];          // hist[k]: instruction issued k+1 advancing edges ago
    int   since_redir;      // advancing edges since the last redirect edge
    int   m_stall, m_flush, m_sstall, m_sflush;
    logic e_stall, e_flush;
    int   e_rs_sel, e_rt_sel;

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < NS; k++) hist.push_back('0);
        since_redir = FD;
        m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;
    endfunction

    function automatic int nearest(logic rd_en, logic [4:0] src);
        int n = -1;
        for (int k = NS - 2; k >= 0; k--)
            if (dec_valid && rd_en && src != 0 && hist[k].v && hist[k].rd == src) n = k;
        return n;
    endfunction

    function automatic void model_outputs();
        int  nrs, nrt;
        logic lu;
        nrs = nearest(dec_read_rs, dec_rs);
        nrt = nearest(dec_read_rt, dec_rt);
        e_flush = ex_redirect || (since_redir < FD);
`ifdef PIPE_HAZARD_FWD_EN
        lu = hist[0].ld && (nrs == 0 || nrt == 0);
        e_stall  = lu && !e_flush;
        e_rs_sel = (lu || nrs < 0) ? 0 : nrs + 1;
        e_rt_sel = (lu || nrt < 0) ? 0 : nrt + 1;
`else
        lu = 1'b0;
        e_stall  = (nrs >= 0 || nrt >= 0) && !e_flush && !lu;
        e_rs_sel = 0;
        e_rt_sel = 0;
`endif
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else if (!hold) begin
                model_outputs();
                if (e_stall) begin
                    if (m_stall < 65535) m_stall++;
                    if (m_sstall < 3) m_sstall++;
                end
                if (ex_redirect) begin
                    if (m_flush < 65535) m_flush++;
                    if (m_sflush < 3) m_sflush++;
                end
                hist.push_front('{v: dec_valid && dec_we && dec_rd != 0 && !e_stall && !e_flush,
                                  rd: dec_rd, ld: dec_is_load});
                void'(hist.pop_back());
                if (ex_redirect) since_redir = 1;
                else if (since_redir < FD) since_redir++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            model_outputs();
            chk("raw_stall", 32'(raw_stall), 32'(e_stall));
            chk("flush_dec", 32'(flush_dec), 32'(e_flush));
            chk("fwd_rs_sel", 32'(fwd_rs_sel), e_rs_sel);
            chk("fwd_rt_sel", 32'(fwd_rt_sel), e_rt_sel);
            chk("stall_cnt", 32'(stall_cnt), m_stall);
            chk("flush_cnt", 32'(flush_cnt), m_flush);
            chk("sat_raw_stall", 32'(s_raw_stall), 32'(e_stall));
            chk("sat_flush_dec", 32'(s_flush_dec), 32'(e_flush));
            chk("sat_fwd_sel", 32'({s_fwd_rs_sel, s_fwd_rt_sel}), (e_rs_sel << 2) | e_rt_sel);
            chk("sat_stall_cnt", 32'(s_stall_cnt), m_sstall);
            chk("sat_flush_cnt", 32'(s_flush_cnt), m_sflush);
        end
    end

    // ---------------- stimulus ----------------
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic instr(input logic we, input logic [4:0] rd, input logic ld,
                         input logic rrs, input logic [4:0] rs,
                         input logic rrt, input logic [4:0] rt);
        dec_valid = 1'b1; dec_we = we; dec_rd = rd; dec_is_load = ld;
        dec_read_rs = rrs; dec_rs = rs; dec_read_rt = rrt; dec_rt = rt;
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_we = 1'b0; dec_rd = '0; dec_is_load = 1'b0;
        dec_read_rs = 1'b0; dec_rs = '0; dec_read_rt = 1'b0; dec_rt = '0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset raw_stall", 32'(raw_stall), 0);
        chk("reset stall_cnt", 32'(stall_cnt), 0);
        next();
        reset_n = 1'b1;

        // addi r5 ; add r6,r5,r5
        instr(1, 5, 0, 0, 0, 0, 0);
        @(negedge clock); chk("A issue stall", 32'(raw_stall), 0);
        next(); instr(1, 6, 0, 1, 5, 1, 5);
        @(negedge clock); chk("A stall c1", 32'(raw_stall), FWD ? 0 : 1);
        chk("A rs_sel c1", 32'(fwd_rs_sel), FWD ? 1 : 0);
        chk("A rt_sel c1", 32'(fwd_rt_sel), FWD ? 1 : 0);
        next();
        @(negedge clock); chk("A stall c2", 32'(raw_stall), FWD ? 0 : 1);
        chk("A rs_sel c2", 32'(fwd_rs_sel), FWD ? 2 : 0);
        next();
        @(negedge clock); chk("A stall c3", 32'(raw_stall), 0);
        chk("A stall_cnt", 32'(stall_cnt), FWD ? 0 : 2);

        // write r7 then two redirects while decode reads r7
        next(); instr(1, 7, 0, 0, 0, 0, 0);
        next(); instr(0, 0, 0, 1, 7, 0, 0); ex_redirect = 1'b1;
        @(negedge clock); chk("R0 flush", 32'(flush_dec), 1);
        chk("R0 stall", 32'(raw_stall), 0);
        next();
        @(negedge clock); chk("R1 flush", 32'(flush_dec), 1);
        chk("R1 stall", 32'(raw_stall), 0);
        next(); ex_redirect = 1'b0; idle();
        @(negedge clock); chk("R2 flush", 32'(flush_dec), 1);
        next();
        @(negedge clock); chk("R3 flush", 32'(flush_dec), 0);
        chk("R flush_cnt", 32'(flush_cnt), 2);
        chk("R stall_cnt", 32'(stall_cnt), FWD ? 0 : 2);

        // hold for 4 cycles during a stall on r9
        next(); instr(1, 9, 0, 0, 0, 0, 0);
        next(); instr(0, 0, 0, 1, 9, 0, 0); hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("H stall", 32'(raw_stall), FWD ? 0 : 1);
            chk("H stall_cnt", 32'(stall_cnt), FWD ? 0 : 2);
            next();
        end
        hold = 1'b0;
        @(negedge clock); chk("H rel c1", 32'(raw_stall), FWD ? 0 : 1);
        next();
        @(negedge clock); chk("H rel c2", 32'(raw_stall), FWD ? 0 : 1);
        next();
        @(negedge clock); chk("H rel c3", 32'(raw_stall), 0);
        chk("H stall_cnt end", 32'(stall_cnt), FWD ? 0 : 4);
        chk("H sat stall_cnt", 32'(s_stall_cnt), FWD ? 0 : 3);

        // r0 never matches
        next(); instr(1, 0, 0, 0, 0, 0, 0);
        next(); instr(1, 3, 0, 1, 0, 1, 0);
        @(negedge clock); chk("r0 stall", 32'(raw_stall), 0);

        // lw r8 ; sub r9,r8,r1
        next(); instr(1, 8, 1, 0, 0, 0, 0);
        next(); instr(1, 9, 0, 1, 8, 1, 1);
        @(negedge clock); chk("L stall c1", 32'(raw_stall), 1);
        chk("L rs_sel c1", 32'(fwd_rs_sel), 0);
        next();
        @(negedge clock); chk("L stall c2", 32'(raw_stall), FWD ? 0 : 1);
        chk("L rs_sel c2", 32'(fwd_rs_sel), FWD ? 2 : 0);
        next();
        @(negedge clock); chk("L stall c3", 32'(raw_stall), 0);

        // reset mid-stall and mid-flush
        next(); instr(1, 10, 0, 0, 0, 0, 0);
        next(); instr(0, 0, 0, 1, 10, 0, 0); ex_redirect = 1'b1;
        next(); ex_redirect = 1'b0; reset_n = 1'b0;
        @(negedge clock); chk("RST stall", 32'(raw_stall), 0);
        chk("RST flush", 32'(flush_dec), 0);
        chk("RST stall_cnt", 32'(stall_cnt), 0);
        chk("RST flush_cnt", 32'(flush_cnt), 0);
        next(); ex_redirect = 1'b1;
        @(negedge clock); chk("RST flush follows redirect", 32'(flush_dec), 1);
        next(); ex_redirect = 1'b0; reset_n = 1'b1;
        @(negedge clock); chk("RST sb empty", 32'(raw_stall), 0);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            next();
            reset_n     = ($urandom_range(0, 199) != 0);
            hold        = ($urandom_range(0, 7) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            dec_valid   = ($urandom_range(0, 7) != 0);
            dec_we      = $urandom_range(0, 1);
            dec_rd      = 5'($urandom_range(0, 3));
            dec_is_load = $urandom_range(0, 1);
            dec_read_rs = $urandom_range(0, 1);
            dec_read_rt = $urandom_range(0, 1);
            dec_rs      = 5'($urandom_range(0, 3));
            dec_rt      = 5'($urandom_range(0, 3));
        end
        next(); reset_n = 1'b1; hold = 1'b0; ex_redirect = 1'b0; idle();
        repeat (3) next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
